// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter slice.
package rf_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef logic [0:0] state_t;
  localparam state_t PIPE_PRI = 1'b0;
  localparam state_t MC_FORCE = 1'b1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
  } wb_req_t;

  // One-hot register mask; x0 never appears in it.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    return (rd == ZERO_REG) ? '0 : (NUM_REGS'(1) << rd);
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback sources, decode issue and register-file write port bundle.
interface rf_wb_arbiter_if;
  import rf_pkg::*;

  logic                  pipe_we_i;
  logic [REG_ADDR_W-1:0] pipe_rd_i;
  logic [XLEN-1:0]       pipe_wd_i;
  logic                  pipe_stall_o;

  logic                  mc_valid_i;
  logic [REG_ADDR_W-1:0] mc_rd_i;
  logic [XLEN-1:0]       mc_wd_i;
  logic                  mc_ready_o;

  logic                  mc_issue_i;
  logic [REG_ADDR_W-1:0] mc_issue_rd_i;
  logic [NUM_REGS-1:0]   busy_o;

  logic                  WE3_o;
  logic [REG_ADDR_W-1:0] A3_o;
  logic [XLEN-1:0]       WD3_o;

  modport master (
    output pipe_we_i, pipe_rd_i, pipe_wd_i, mc_valid_i, mc_rd_i, mc_wd_i,
           mc_issue_i, mc_issue_rd_i,
    input  pipe_stall_o, mc_ready_o, busy_o, WE3_o, A3_o, WD3_o
  );

  modport slave (
    input  pipe_we_i, pipe_rd_i, pipe_wd_i, mc_valid_i, mc_rd_i, mc_wd_i,
           mc_issue_i, mc_issue_rd_i,
    output pipe_stall_o, mc_ready_o, busy_o, WE3_o, A3_o, WD3_o
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Pending multi-cycle destination vector: set on issue, clear on retire, set wins.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  output logic [NUM_REGS-1:0]   busy
);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = set_en ? rd_onehot(set_rd) : '0;
    clr_mask = clr_en ? rd_onehot(clr_rd) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= (busy & ~clr_mask) | set_mask;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: pipeline priority, starvation-forced
// multi-cycle grant, and the pending-destination scoreboard for decode.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input logic           clk,
  input logic           rst,
  rf_wb_arbiter_if.slave wb
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                pipe_req;
  logic                wr_en;
  wb_req_t             wr;
  wb_req_t             pipe_wr;
  wb_req_t             mc_wr;
  logic                stall;
  logic                ready;
  logic [NUM_REGS-1:0] busy;

  always_comb begin
    pipe_req = wb.pipe_we_i && (wb.pipe_rd_i != ZERO_REG);
    pipe_wr  = '{rd: wb.pipe_rd_i, wd: wb.pipe_wd_i};
    mc_wr    = '{rd: wb.mc_rd_i,   wd: wb.mc_wd_i};
    cnt_inc  = cnt_q + CNT_W'(1);
  end

  // Grant, stall and next state; the write port is combinational so the
  // register file captures the winner at the same edge as the grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    ready   = 1'b0;
    wr_en   = 1'b0;
    wr      = '0;

    if (state_q == MC_FORCE) begin
      stall   = 1'b1;
      ready   = wb.mc_valid_i;
      wr_en   = wb.mc_valid_i && (wb.mc_rd_i != ZERO_REG);
      wr      = mc_wr;
      state_d = PIPE_PRI;
      cnt_d   = '0;
    end else begin
      if (pipe_req) begin
        wr_en = 1'b1;
        wr    = pipe_wr;
      end else if (wb.mc_valid_i) begin
        ready = 1'b1;
        wr_en = wb.mc_rd_i != ZERO_REG;
        wr    = mc_wr;
      end

      if (wb.mc_valid_i && !ready) begin
        if (cnt_inc == CNT_W'(STARVE_LIMIT)) begin
          state_d = MC_FORCE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        cnt_d = '0;
      end
    end

    if (!wr_en) wr = '0;

    // Outputs read as zero for as long as reset is held.
    if (!rst) begin
      stall = 1'b0;
      ready = 1'b0;
      wr_en = 1'b0;
      wr    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PIPE_PRI;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  rf_scoreboard u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .set_en (wb.mc_issue_i),
    .set_rd (wb.mc_issue_rd_i),
    .clr_en (ready),
    .clr_rd (wb.mc_rd_i),
    .busy   (busy)
  );

  assign wb.pipe_stall_o = stall;
  assign wb.mc_ready_o   = ready;
  assign wb.WE3_o        = wr_en;
  assign wb.A3_o         = wr.rd;
  assign wb.WD3_o        = wr.wd;
  assign wb.busy_o       = busy;

  // Decode must not issue to a busy rd unless that rd retires this same cycle.
  a_issue_busy: assert property (@(posedge clk) disable iff (!rst)
    !(wb.mc_issue_i && (wb.mc_issue_rd_i != ZERO_REG) && busy[wb.mc_issue_rd_i] &&
      !(ready && (wb.mc_rd_i == wb.mc_issue_rd_i))));

  // A pipeline write landing on a register still owed by the multi-cycle unit.
  a_pipe_busy: assert property (@(posedge clk) disable iff (!rst)
    !((state_q == PIPE_PRI) && pipe_req && busy[wb.pipe_rd_i]));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboarded random + directed bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wb_arbiter_if wb();

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        ready;
    logic        stall;
    logic [31:0] busy;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference state: refused streak, pending forced slot, pending-write set.
  int          m_streak;
  bit          m_force;
  logic [31:0] m_busy;
  bit          m_stall_prev;
  bit          m_ready_now;
  logic        h_we;
  logic [4:0]  h_rd;
  logic [31:0] h_wd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_streak = 0; m_force = 1'b0; m_busy = '0; m_stall_prev = 1'b0; m_ready_now = 1'b0;
    h_we = 1'b0; h_rd = '0; h_wd = '0;
  endtask

  task automatic set_idle();
    wb.pipe_we_i = 1'b0; wb.pipe_rd_i = '0; wb.pipe_wd_i = '0;
    wb.mc_valid_i = 1'b0; wb.mc_rd_i = '0; wb.mc_wd_i = '0;
    wb.mc_issue_i = 1'b0; wb.mc_issue_rd_i = '0;
  endtask

  // Drive one cycle, predict its outcome, queue the prediction, step to posedge+1.
  task automatic drive(input bit pwe, input logic [4:0] prd, input logic [31:0] pwd,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] mwd,
                       input bit iss, input logic [4:0] ird);
    exp_t e;
    logic [31:0] nb;
    bit preq;
    if (m_stall_prev) begin pwe = h_we; prd = h_rd; pwd = h_wd; end
    h_we = pwe; h_rd = prd; h_wd = pwd;
    wb.pipe_we_i = pwe; wb.pipe_rd_i = prd; wb.pipe_wd_i = pwd;
    wb.mc_valid_i = mv; wb.mc_rd_i = mrd; wb.mc_wd_i = mwd;
    wb.mc_issue_i = iss; wb.mc_issue_rd_i = ird;

    e.we = 1'b0; e.a3 = '0; e.wd3 = '0; e.ready = 1'b0; e.stall = 1'b0;
    e.busy = m_busy; e.id = cyc;
    preq = pwe && (prd != 5'd0);
    if (m_force) begin
      e.stall = 1'b1;
      e.ready = mv;
      if (mv && mrd != 5'd0) begin e.we = 1'b1; e.a3 = mrd; e.wd3 = mwd; end
      m_force = 1'b0;
      m_streak = 0;
    end else begin
      if (preq) begin
        e.we = 1'b1; e.a3 = prd; e.wd3 = pwd;
      end else if (mv) begin
        e.ready = 1'b1;
        if (mrd != 5'd0) begin e.we = 1'b1; e.a3 = mrd; e.wd3 = mwd; end
      end
      if (mv && !e.ready) begin
        m_streak++;
        if (m_streak == int'(LIMIT)) begin m_force = 1'b1; m_streak = 0; end
      end else begin
        m_streak = 0;
      end
    end
    nb = m_busy;
    if (mv && e.ready) nb[mrd] = 1'b0;
    if (iss) nb[ird] = 1'b1;
    nb[0] = 1'b0;
    m_busy = nb;
    m_stall_prev = e.stall;
    m_ready_now = e.ready;
    exp_q.push_back(e);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT against each queued prediction mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("c%0d WE3", e.id),   64'(wb.WE3_o),        64'(e.we));
        check($sformatf("c%0d A3", e.id),    64'(wb.A3_o),         64'(e.a3));
        check($sformatf("c%0d WD3", e.id),   64'(wb.WD3_o),        64'(e.wd3));
        check($sformatf("c%0d ready", e.id), 64'(wb.mc_ready_o),   64'(e.ready));
        check($sformatf("c%0d stall", e.id), 64'(wb.pipe_stall_o), 64'(e.stall));
        check($sformatf("c%0d busy", e.id),  64'(wb.busy_o),       64'(e.busy));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          mv;
    logic [4:0]  mrd;
    logic [31:0] mwd;
    logic [4:0]  outq[$];
    bit          pwe, iss;
    logic [4:0]  prd, ird, eff_prd;
    logic [31:0] pwd;

    rst = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("reset WE3", 64'(wb.WE3_o), 64'd0);
    check("reset busy", 64'(wb.busy_o), 64'd0);

    // Reset in the middle of traffic with x4 pending.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd4);
    check("pre-reset busy", 64'(wb.busy_o), 64'h10);
    wb.pipe_we_i = 1'b1; wb.pipe_rd_i = 5'd3; wb.pipe_wd_i = 32'h1234;
    wb.mc_valid_i = 1'b1; wb.mc_rd_i = 5'd4; wb.mc_wd_i = 32'h55;
    #1;
    rst = 1'b0;
    #1;
    check("async WE3", 64'(wb.WE3_o), 64'd0);
    check("async A3", 64'(wb.A3_o), 64'd0);
    check("async WD3", 64'(wb.WD3_o), 64'd0);
    check("async ready", 64'(wb.mc_ready_o), 64'd0);
    check("async stall", 64'(wb.pipe_stall_o), 64'd0);
    check("async busy", 64'(wb.busy_o), 64'd0);
    @(posedge clk);
    #1;
    set_idle();
    rst = 1'b1;
    model_reset();

    // Directed: issue, idle-pipe grant, starvation, x0 cases, set/clear race.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd5);
    drive(0, 0, 0, 0, 0, 0, 1, 5'd7);
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9);
    drive(0, 0, 0, 0, 0, 0, 1, 5'd4);
    drive(0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      drive(1, 5'(10 + i), 32'(32'hA000 + i), i < 5, 5'd7, 32'h7777_0007, 0, 0);
    drive(1, 5'd0, 32'h0BAD, 1, 5'd4, 32'h4444, 0, 0);
    drive(0, 0, 0, 1, 5'd9, 32'h9999, 1, 5'd9);
    drive(0, 0, 0, 0, 0, 0, 1, 5'd0);
    drive(0, 0, 0, 1, 5'd0, 32'hFFFF_0000, 0, 0);
    drive(0, 0, 0, 1, 5'd9, 32'h9A9A, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic obeying the decode and handshake obligations.
    mv = 1'b0; mrd = '0; mwd = '0;
    for (int c = 0; c < 2000; c++) begin
      if (!mv && outq.size() > 0 && $urandom_range(0, 2) != 0) begin
        mv = 1'b1; mrd = outq.pop_front(); mwd = $urandom;
      end
      pwe = $urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 8 : 3);
      prd = 5'($urandom);
      if (m_busy[prd]) prd = 5'd0;
      pwd = $urandom;
      eff_prd = m_stall_prev ? h_rd : prd;
      iss = ($urandom_range(0, 3) == 0) && (outq.size() < 8);
      ird = 5'($urandom);
      if (m_busy[ird] || (ird == eff_prd && ird != 5'd0)) iss = 1'b0;
      if (iss) outq.push_back(ird);
      drive(pwe, prd, pwd, mv, mrd, mwd, iss, iss ? ird : 5'd0);
      if (mv && m_ready_now) mv = 1'b0;
    end

    set_idle();
    @(negedge clk);
    #1;
    check("queue drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single register-file write port (WE3/A3/WD3) and shares it between two writeback sources:
  - the in-order pipeline writeback stage;
  - a multi-cycle unit (divider / slow load) using a valid/ready handshake.
- Pipeline has priority. A starvation counter forces a one-cycle pipeline stall so the multi-cycle result can retire.
- Keeps a 32-bit pending-destination scoreboard that decode uses for RAW/WAW stalls.
- Sits between the writeback stage, the multi-cycle unit, decode, and Register_File.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles mc_valid_i may be refused before a forced grant (legal 1..15).
- CNT_W, 4: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- pipe_we_i  in  1  pipeline writeback request this cycle.
- pipe_rd_i  in  5  pipeline destination register.
- pipe_wd_i  in  32  pipeline write data.
- pipe_stall_o  out  1  freeze the pipeline this cycle; the writeback stage holds its request.
- mc_valid_i  in  1  multi-cycle result available; held with rd/data stable until accepted.
- mc_rd_i  in  5  multi-cycle destination.
- mc_wd_i  in  32  multi-cycle data.
- mc_ready_o  out  1  multi-cycle result accepted this cycle.
- mc_issue_i  in  1  decode issues an op to the multi-cycle unit.
- mc_issue_rd_i  in  5  destination of the issued op.
- busy_o  out  32  bit n=1: register n has an outstanding multi-cycle write.
- WE3_o  out  1  register-file write enable.
- A3_o  out  5  register-file write address.
- WD3_o  out  32  register-file write data.

Behaviour:
- Reset (rst=0, async), held while low:
  - state=PIPE_PRI, starve_cnt=0, busy=0;
  - WE3_o=0, A3_o=0, WD3_o=0, mc_ready_o=0, pipe_stall_o=0, busy_o=0.
- Outputs to the register file are combinational from the current state and inputs, so the write lands at the same edge as the grant (zero added latency).
- Effective pipe request: pipe_req = pipe_we_i & (pipe_rd_i!=0).
- State PIPE_PRI:
  - pipe_stall_o=0.
  - If pipe_req: WE3_o=1, A3_o/WD3_o=pipe; mc_ready_o=0.
  - Else if mc_valid_i: mc_ready_o=1; write mc (WE3_o=0 when mc_rd_i==0 — result accepted and dropped).
  - starve_cnt: +1 when mc_valid_i & ~mc_ready_o; cleared on any mc accept or when mc_valid_i=0.
  - When the increment makes starve_cnt==STARVE_LIMIT: next state MC_FORCE, starve_cnt=0.
- State MC_FORCE (exactly one cycle):
  - pipe_stall_o=1; mc_ready_o=mc_valid_i; write mc as above; pipe request ignored, not written.
  - Next state PIPE_PRI.
  - If mc_valid_i=0 here (protocol violation), return with no write; the stall is still asserted.
- Never two writes in one cycle. A3_o and WD3_o are 0 whenever WE3_o=0.
- Scoreboard:
  - set bit mc_issue_rd_i on mc_issue_i (ignored for rd 0);
  - clear bit mc_rd_i on mc_valid_i & mc_ready_o;
  - same rd set and cleared in one cycle: set wins.
  - Bit 0 is always 0.
- Decode obligations (outside this block):
  - stall any source or destination with busy_o set;
  - never issue to a busy rd.
  - Violations are flagged by a simulation assertion.
- A pipeline write to a busy rd is an error (assertion); it is still written.

Decomposition:
- Shared package rf_pkg: REG_ADDR_W=5, XLEN=32, NUM_REGS=32, the state enum (PIPE_PRI, MC_FORCE), and the zero-register constant.
- One natural sub-module, rf_scoreboard: the 32-bit set/clear vector with set-priority and x0 masking.
- Arbitration FSM and counter stay in the top level.

Test Plan:
- Reset: drive rst=0 mid-traffic with busy_o=0x0000_0010 → all outputs 0 immediately (async), busy_o=0, state PIPE_PRI after release.
- Idle pipe: pipe_we_i=0, mc_valid_i=1, rd=5, wd=0xDEAD_BEEF → same cycle mc_ready_o=1, WE3_o=1, A3_o=5, WD3_o=0xDEAD_BEEF; busy bit 5 cleared next edge.
- Starvation: pipe_req every cycle, mc_valid_i=1 (rd=7) → mc refused 4 cycles, 5th cycle pipe_stall_o=1, A3_o=7; pipe request held and written the cycle after.
- Pipe x0: pipe_we_i=1, pipe_rd_i=0, mc_valid_i=1 → mc granted that cycle; WE3_o driven by mc only.
- Scoreboard race:
  - mc_issue_i rd=9 in the same cycle as mc accept rd=9 → busy_o[9]=1 afterwards;
  - issue rd=0 → busy_o unchanged.
- mc to x0: mc_valid_i=1, mc_rd_i=0 with pipe idle → mc_ready_o=1, WE3_o=0, no scoreboard change.
